swap_requester: RTL and testbench

- GPU-side initiator of the framebuffer swap handshake.
- Turns a one-cycle `drawDone` pulse from the rasteriser into a `swapIn` level request for the buffer controller.
- Holds `swapIn` until `fbGPU` is seen to toggle (the acknowledge), caps the swap rate to a minimum number of vSync periods, and stalls the GPU while a swap is outstanding.
- Reports frame, drop and timeout statistics to the CPU register file.

---
 rtl/swap_requester_pkg.sv | 15 +
 rtl/edge_detect_rise.sv | 21 ++
 rtl/swap_requester.sv | 128 ++++++++++++
 tb/tb_swap_requester.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swap_requester_pkg.sv
// rtl/swap_requester_pkg.sv - shared graphics constants and swap handshake state encoding
package swap_requester_pkg;

    localparam int CNT_WIDTH_DEF      = 16;
    localparam int TIMEOUT_CYCLES_DEF = 2000000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLDOFF  = 3'd1,
        ASSERT   = 3'd2,
        WAIT_ACK = 3'd3,
        RELEASE  = 3'd4
    } swapState_t;

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - 1-bit rising-edge detector with synchronous reset
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic oldSig;

    always_ff @(posedge clk) begin
        if (reset) begin
            oldSig <= 1'b0;
        end else begin
            oldSig <= sig;
        end
    end

    assign rise = sig && !oldSig;

endmodule

// File: rtl/swap_requester.sv
// rtl/swap_requester.sv - GPU-side framebuffer swap request with vSync rate cap and timeout
module swap_requester
    import swap_requester_pkg::*;
#(
    parameter int MIN_VSYNCS     = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 drawDone,
    input  logic                 vSync,
    input  logic                 fbGPU,
    output logic                 swapIn,
    output logic                 gpuReady,
    output logic [CNT_WIDTH-1:0] frameCount,
    output logic [CNT_WIDTH-1:0] dropCount,
    output logic                 timeoutErr
);

    localparam int VS_W = (MIN_VSYNCS > 0) ? $clog2(MIN_VSYNCS + 1) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [VS_W-1:0] VS_MAX  = VS_W'(MIN_VSYNCS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    swapState_t      state;
    swapState_t      nextState;
    logic            pending;
    logic            fbAtReq;
    logic [VS_W-1:0] vsyncCnt;
    logic [TO_W-1:0] toCnt;
    logic            vsRise;
    logic            ackSeen;
    logic            timedOut;
    logic            swapInNext;

    edge_detect_rise uVsyncEdge (
        .clk  (clk),
        .reset(reset),
        .sig  (vSync),
        .rise (vsRise)
    );

    always_comb begin
        nextState = state;
        ackSeen   = 1'b0;
        timedOut  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) nextState = HOLDOFF;
            end
            HOLDOFF: begin
                if (vsyncCnt == VS_MAX) nextState = ASSERT;
            end
            ASSERT: begin
                nextState = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (fbGPU != fbAtReq) begin
                    nextState = RELEASE;
                    ackSeen   = 1'b1;
                end else if (toCnt == TO_LAST) begin
                    nextState = RELEASE;
                    timedOut  = 1'b1;
                end
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Registered from the next state so the request level is glitch-free at the buffer controller.
    assign swapInNext = (nextState == ASSERT) || (nextState == WAIT_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            swapIn     <= 1'b0;
            pending    <= 1'b0;
            fbAtReq    <= 1'b0;
            vsyncCnt   <= VS_MAX;
            toCnt      <= '0;
            frameCount <= '0;
            dropCount  <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state  <= nextState;
            swapIn <= swapInNext;

            if (drawDone) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end

            if (drawDone && pending && dropCount != '1) begin
                dropCount <= dropCount + 1'b1;
            end

            // The acknowledge restarts the frame-rate window even if a vSync edge lands on it.
            if (ackSeen) begin
                vsyncCnt <= '0;
            end else if (vsRise && vsyncCnt != VS_MAX) begin
                vsyncCnt <= vsyncCnt + 1'b1;
            end

            if (state == HOLDOFF && nextState == ASSERT) begin
                fbAtReq <= fbGPU;
            end

            if (state == ASSERT) begin
                toCnt <= '0;
            end else if (state == WAIT_ACK) begin
                toCnt <= toCnt + 1'b1;
            end

            if (ackSeen) frameCount <= frameCount + 1'b1;
            if (timedOut) timeoutErr <= 1'b1;
        end
    end

    assign gpuReady = (state == IDLE) && !pending;

endmodule

// File: tb/tb_swap_requester.sv
// tb/tb_swap_requester.sv - self-checking bench for swap_requester with behavioural model
module tb_swap_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        drawDone;
    logic        vSync;
    logic [1:0]  fb;
    logic [1:0]  sw;
    logic [1:0]  rdy;
    logic [1:0]  te;
    logic [15:0] fc [2];
    logic [15:0] dc [2];

    int cyc = 0;
    int nChecks = 0;
    int nErr = 0;

    int mode;
    int ackDelay;
    int vsPeriod;
    int vsBase;
    int finishReq;
    int m1, m2, m3, m4, m5, m6;

    int minV [2] = '{1, 2};
    int tmoV [2] = '{600, 50};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    swap_requester #(.MIN_VSYNCS(1), .TIMEOUT_CYCLES(600), .CNT_WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .drawDone(drawDone), .vSync(vSync), .fbGPU(fb[0]),
        .swapIn(sw[0]), .gpuReady(rdy[0]), .frameCount(fc[0]), .dropCount(dc[0]),
        .timeoutErr(te[0])
    );

    swap_requester #(.MIN_VSYNCS(2), .TIMEOUT_CYCLES(50), .CNT_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .drawDone(drawDone), .vSync(vSync), .fbGPU(fb[1]),
        .swapIn(sw[1]), .gpuReady(rdy[1]), .frameCount(fc[1]), .dropCount(dc[1]),
        .timeoutErr(te[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse(input int c);
        waitUntil(c);
        drawDone = 1'b1;
        step();
        drawDone = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // Buffer controller stand-in: acknowledges after a delay, never, or on a vSync rising edge.
    int riseCyc [2];
    bit [1:0] prevSw;
    bit prevVs;
    bit vsEdge;
    initial begin
        fb = 2'b00;
        vSync = 1'b0;
        prevVs = 1'b0;
        prevSw = 2'b00;
        riseCyc[0] = -1000;
        riseCyc[1] = -1000;
        forever begin
            @(posedge clk);
            #2;
            if (vsPeriod > 0 && cyc >= vsBase) vSync = ((cyc - vsBase) % vsPeriod) < (vsPeriod / 2);
            else vSync = 1'b0;
            vsEdge = vSync && !prevVs;
            prevVs = vSync;
            for (int i = 0; i < 2; i++) begin
                if (sw[i] && !prevSw[i]) riseCyc[i] = cyc;
                prevSw[i] = sw[i];
                if (mode == 0 && sw[i] && cyc == riseCyc[i] + ackDelay) fb[i] = ~fb[i];
                if (mode == 2 && sw[i] && vsEdge) fb[i] = ~fb[i];
            end
        end
    end

    // Model: request timeline kept as cycle stamps (holdoff, rise, fall) per instance.
    bit mOn;
    bit mInF [2], mHold [2], mPend [2], mPrevV [2], mFbRef [2], mTmo [2];
    int mRise [2], mFall [2], mEdges [2], mFrames [2], mDrops [2];
    bit [1:0] lastFb;
    int togHigh [2];
    initial begin
        mOn = 1'b0;
        lastFb = 2'b00;
        togHigh[0] = 0;
        togHigh[1] = 0;
        forever begin
            @(negedge clk);
            if (cyc > 20000) begin
                nErr++;
                $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
                $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
                $finish;
            end
            if (reset) begin
                mOn = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    mInF[i] = 0; mHold[i] = 0; mPend[i] = 0; mPrevV[i] = 0; mFbRef[i] = 0;
                    mTmo[i] = 0; mRise[i] = -1; mFall[i] = -1; mEdges[i] = minV[i];
                    mFrames[i] = 0; mDrops[i] = 0;
                end
            end else if (mOn) begin
                for (int i = 0; i < 2; i++) begin
                    bit expSw, rise, ack, start;
                    int n;
                    n = cyc;
                    expSw = mInF[i] && !mHold[i] && n >= mRise[i] && (mFall[i] < 0 || n < mFall[i]);
                    chk($sformatf("swapIn_u%0d", i), int'(sw[i]), int'(expSw));
                    chk($sformatf("gpuReady_u%0d", i), int'(rdy[i]), int'(!mInF[i] && !mPend[i]));
                    chk($sformatf("frameCount_u%0d", i), int'(fc[i]), mFrames[i] & 16'hFFFF);
                    chk($sformatf("dropCount_u%0d", i), int'(dc[i]), mDrops[i]);
                    chk($sformatf("timeoutErr_u%0d", i), int'(te[i]), int'(mTmo[i]));

                    if (fb[i] != lastFb[i] && sw[i]) begin
                        togHigh[i]++;
                        chk($sformatf("one_ack_per_request_u%0d", i), int'(togHigh[i] <= 1), 1);
                    end
                    if (!sw[i]) togHigh[i] = 0;

                    rise = vSync && !mPrevV[i];
                    ack = 1'b0;
                    start = !mInF[i] && mPend[i];
                    if (mInF[i] && !mHold[i] && n > mRise[i] && mFall[i] < 0) begin
                        if (fb[i] != mFbRef[i]) begin
                            mFall[i] = n + 1;
                            mFrames[i]++;
                            ack = 1'b1;
                        end else if (n - mRise[i] - 1 == tmoV[i] - 1) begin
                            mFall[i] = n + 1;
                            mTmo[i] = 1'b1;
                        end
                    end
                    if (mInF[i] && mHold[i] && mEdges[i] >= minV[i]) begin
                        mHold[i] = 1'b0;
                        mRise[i] = n + 1;
                        mFbRef[i] = fb[i];
                    end
                    if (ack) mEdges[i] = 0;
                    else if (rise && mEdges[i] < minV[i]) mEdges[i]++;
                    mPrevV[i] = vSync;
                    if (mInF[i] && mFall[i] >= 0 && n == mFall[i]) mInF[i] = 1'b0;
                    if (start) begin
                        mInF[i] = 1'b1;
                        mHold[i] = 1'b1;
                        mFall[i] = -1;
                    end
                    if (drawDone) begin
                        if (mPend[i] && mDrops[i] < 65535) mDrops[i]++;
                        mPend[i] = 1'b1;
                    end else if (start) begin
                        mPend[i] = 1'b0;
                    end
                end

                // Hand-derived anchors for the model
                for (int i = 0; i < 2; i++) begin
                    if (cyc == m1) chk("t1_reset_ready", int'(rdy[i]), 1);
                    if (cyc == m1) chk("t1_reset_swap", int'(sw[i]), 0);
                    if (cyc == m1 + 12) chk("t1_swap_before_rise", int'(sw[i]), 0);
                    if (cyc == m1 + 13) chk("t1_swap_rise", int'(sw[i]), 1);
                    if (cyc == m1 + 20) chk("t1_swap_at_ack", int'(sw[i]), 1);
                    if (cyc == m1 + 21) chk("t1_swap_fall", int'(sw[i]), 0);
                    if (cyc == m1 + 21) chk("t1_frames", int'(fc[i]), 1);
                    if (cyc == m1 + 21) chk("t1_ready_release", int'(rdy[i]), 0);
                    if (cyc == m1 + 22) chk("t1_ready_back", int'(rdy[i]), 1);
                    if (cyc == m3 + 260) chk("t3_frames", int'(fc[i]), 2);
                    if (cyc == m3 + 260) chk("t3_drops", int'(dc[i]), 2);
                    if (cyc == m5 + 11) begin
                        chk("t5_swap_reset", int'(sw[i]), 0);
                        chk("t5_frames_reset", int'(fc[i]), 0);
                        chk("t5_drops_reset", int'(dc[i]), 0);
                        chk("t5_timeout_reset", int'(te[i]), 0);
                        chk("t5_ready_reset", int'(rdy[i]), 1);
                    end
                    if (cyc == m5 + 22) chk("t5_swap_before_rise", int'(sw[i]), 0);
                    if (cyc == m5 + 23) chk("t5_swap_rise", int'(sw[i]), 1);
                end
                if (cyc == m2 + 101) chk("t2_u0_swap_low", int'(sw[0]), 0);
                if (cyc == m2 + 102) chk("t2_u0_swap_rise", int'(sw[0]), 1);
                if (cyc == m2 + 201) chk("t2_u1_swap_low", int'(sw[1]), 0);
                if (cyc == m2 + 202) chk("t2_u1_swap_rise", int'(sw[1]), 1);
                if (cyc == m4 + 53) chk("t4_swap_before_timeout", int'(sw[1]), 1);
                if (cyc == m4 + 53) chk("t4_err_before_timeout", int'(te[1]), 0);
                if (cyc == m4 + 54) chk("t4_swap_timeout_fall", int'(sw[1]), 0);
                if (cyc == m4 + 54) chk("t4_err_set", int'(te[1]), 1);
                if (cyc == m4 + 110) chk("t4_err_sticky", int'(te[1]), 1);
                if (cyc == m4 + 110) chk("t4_no_frames", int'(fc[1]), 0);
                if (cyc == m4 + 122) chk("t4_retry_low", int'(sw[1]), 0);
                if (cyc == m4 + 123) chk("t4_retry_rise", int'(sw[1]), 1);
                if (cyc == m6 + 1900) chk("t6_frames", int'(fc[0]), 4);
                if (cyc == m6 + 1900) chk("t6_drops", int'(dc[0]), 1);
            end
            lastFb = fb;
            if (finishReq != 0) begin
                $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
                $finish;
            end
        end
    end

    initial begin
        int b;
        reset = 1'b1;
        drawDone = 1'b0;
        mode = 0;
        ackDelay = 7;
        vsPeriod = 0;
        vsBase = 0;
        finishReq = 0;
        m1 = -100000; m2 = -100000; m3 = -100000;
        m4 = -100000; m5 = -100000; m6 = -100000;
        repeat (3) step();
        reset = 1'b0;

        // basic swap, acknowledge 7 cycles after the rise
        m1 = cyc;
        pulse(m1 + 10);
        waitUntil(m1 + 40);

        // vSync holdoff between consecutive swaps
        doReset();
        b = cyc;
        m2 = b;
        vsBase = b + 100;
        vsPeriod = 100;
        pulse(b);
        pulse(b + 5);
        waitUntil(b + 300);
        vsPeriod = 0;

        // overrun during a long WAIT_ACK
        doReset();
        b = cyc;
        m3 = b;
        ackDelay = 40;
        vsBase = b + 60;
        vsPeriod = 50;
        pulse(b);
        pulse(b + 10);
        pulse(b + 15);
        pulse(b + 20);
        waitUntil(b + 270);
        vsPeriod = 0;
        ackDelay = 7;

        // acknowledge withheld
        doReset();
        mode = 1;
        b = cyc;
        m4 = b;
        pulse(b);
        pulse(b + 120);
        waitUntil(b + 200);

        // reset in the middle of WAIT_ACK
        b = cyc;
        m5 = b;
        pulse(b);
        waitUntil(b + 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode = 0;
        pulse(b + 20);
        waitUntil(b + 60);

        // closed loop with a vSync-synchronised buffer controller
        doReset();
        mode = 2;
        b = cyc;
        m6 = b;
        vsBase = b + 10;
        vsPeriod = 250;
        for (int k = 0; k < 5; k++) pulse(b + 20 + 300 * k);
        waitUntil(b + 1905);
        finishReq = 1;
    end

endmodule
